// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared types and constants for the sprite ROM arbiter: player state encoding,
// sprite frame indices, return-tag layout and the state-to-frame mapping.
package sprite_rom_arbiter_pkg;

   localparam int unsigned STATE_W      = 4;
   localparam int unsigned SPR_IDX_W    = 3;
   localparam int unsigned DEF_SPRITE_W = 100;
   localparam int unsigned DEF_SPRITE_H = 100;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = 4'd0,
      ST_FWD       = 4'd1,
      ST_BACK      = 4'd2,
      ST_ATK_START = 4'd3,
      ST_ATK_END   = 4'd4,
      ST_ATK_PULL  = 4'd5
   } player_state_e;

   localparam logic [SPR_IDX_W-1:0] SPR_IDLE      = 3'd0;
   localparam logic [SPR_IDX_W-1:0] SPR_MOVE      = 3'd1;
   localparam logic [SPR_IDX_W-1:0] SPR_ATK_START = 3'd2;
   localparam logic [SPR_IDX_W-1:0] SPR_ATK_END   = 3'd3;
   localparam logic [SPR_IDX_W-1:0] SPR_ATK_PULL  = 3'd4;

   // One in-flight ROM read: who asked, and whether it was out of the sprite box.
   typedef struct packed {
      logic valid;
      logic who;
      logic oob;
   } tag_t;

   // Forward and back movement share a frame; unknown states fall back to idle.
   function automatic logic [SPR_IDX_W-1:0] state_to_sprite(input logic [STATE_W-1:0] st);
      case (st)
         ST_IDLE:      return SPR_IDLE;
         ST_FWD:       return SPR_MOVE;
         ST_BACK:      return SPR_MOVE;
         ST_ATK_START: return SPR_ATK_START;
         ST_ATK_END:   return SPR_ATK_END;
         ST_ATK_PULL:  return SPR_ATK_PULL;
         default:      return SPR_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Per-player fetch port: renderer drives request and coordinates, arbiter
// returns grant and tagged pixel data.
interface sprite_rom_arbiter_if #(
   parameter int unsigned CRD_W  = 7,
   parameter int unsigned DATA_W = 16
) ();
   logic              req;
   logic [CRD_W-1:0]  px;
   logic [CRD_W-1:0]  py;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (output req, px, py, input gnt, rvalid, rdata);
   modport slave  (input req, px, py, output gnt, rvalid, rdata);
endinterface

// File: rtl/sprite_rom_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner and only
// moves when a grant is issued.
module sprite_rom_arbiter_rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt_c
);
   logic last_q;  // 1: requester 1 won most recently

   always_comb begin
      gnt_c = 2'b00;
      if (!rst) begin
         if (req == 2'b11) gnt_c = last_q ? 2'b01 : 2'b10;
         else              gnt_c = req;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)         last_q <= 1'b1;
      else if (|gnt_c) last_q <= gnt_c[1];
   end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one sprite ROM between two player renderers: latches each player's
// frame at frame start, arbitrates fetches and routes tagged read data back.
module sprite_rom_arbiter
   import sprite_rom_arbiter_pkg::*;
#(
   parameter int unsigned SPRITE_W    = DEF_SPRITE_W,
   parameter int unsigned SPRITE_H    = DEF_SPRITE_H,
   parameter int unsigned NUM_SPRITES = 5,
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned ROM_LAT     = 1,
   parameter int unsigned CRD_W       = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_start,
   input  logic [STATE_W-1:0]    p0_state,
   input  logic [STATE_W-1:0]    p1_state,
   sprite_rom_arbiter_if.slave   p0,
   sprite_rom_arbiter_if.slave   p1,
   output logic                  rom_en,
   output logic [ADDR_W-1:0]     rom_addr,
   input  logic [DATA_W-1:0]     rom_data
);
   localparam int unsigned FRAME_SZ = SPRITE_W * SPRITE_H;

   logic [SPR_IDX_W-1:0] idx0_q, idx1_q;
   logic [SPR_IDX_W-1:0] spr0_c, spr1_c;
   logic [CRD_W-1:0]     px0_c, py0_c, px1_c, py1_c;
   logic [ADDR_W-1:0]    addr0_c, addr1_c;
   logic                 oob0_c, oob1_c, sel_oob_c;
   logic [1:0]           gnt_c;
   tag_t                 tag_in_c, ret_c;
   tag_t                 tag_q [ROM_LAT];
   logic [DATA_W-1:0]    ret_data_c, rdata0_q, rdata1_q;
   logic                 rvalid0_c, rvalid1_c;

   assign px0_c = p0.px;
   assign py0_c = p0.py;
   assign px1_c = p1.px;
   assign py1_c = p1.py;

   // Frame choice is frozen for the whole frame; a same-cycle fetch still sees the old one.
   always_comb begin
      spr0_c = state_to_sprite(p0_state);
      spr1_c = state_to_sprite(p1_state);
      if (32'(spr0_c) >= NUM_SPRITES) spr0_c = SPR_IDLE;
      if (32'(spr1_c) >= NUM_SPRITES) spr1_c = SPR_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx0_q <= SPR_IDLE;
         idx1_q <= SPR_IDLE;
      end else if (frame_start) begin
         idx0_q <= spr0_c;
         idx1_q <= spr1_c;
      end
   end

   always_comb begin
      addr0_c = ADDR_W'(idx0_q) * ADDR_W'(FRAME_SZ) + ADDR_W'(py0_c) * ADDR_W'(SPRITE_W) + ADDR_W'(px0_c);
      addr1_c = ADDR_W'(idx1_q) * ADDR_W'(FRAME_SZ) + ADDR_W'(py1_c) * ADDR_W'(SPRITE_W) + ADDR_W'(px1_c);
      oob0_c  = (32'(px0_c) >= SPRITE_W) || (32'(py0_c) >= SPRITE_H);
      oob1_c  = (32'(px1_c) >= SPRITE_W) || (32'(py1_c) >= SPRITE_H);
   end

   sprite_rom_arbiter_rr_arbiter2 u_rr (
      .clk   (clk),
      .rst   (rst),
      .req   ({p1.req, p0.req}),
      .gnt_c (gnt_c)
   );

   assign p0.gnt = gnt_c[0];
   assign p1.gnt = gnt_c[1];

   // Out-of-box fetches are granted but never touch the ROM.
   always_comb begin
      sel_oob_c = gnt_c[1] ? oob1_c : oob0_c;
      rom_en    = 1'b0;
      rom_addr  = '0;
      if (|gnt_c) begin
         rom_en   = !sel_oob_c;
         rom_addr = gnt_c[1] ? addr1_c : addr0_c;
      end
      tag_in_c = '{valid: |gnt_c, who: gnt_c[1], oob: sel_oob_c};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ROM_LAT; i++) tag_q[i] <= '0;
      end else begin
         tag_q[0] <= tag_in_c;
         for (int i = 1; i < ROM_LAT; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   // Tag leaves the pipe in the same cycle the ROM presents its data.
   always_comb begin
      ret_c      = tag_q[ROM_LAT-1];
      ret_data_c = ret_c.oob ? '0 : rom_data;
      rvalid0_c  = !rst && ret_c.valid && !ret_c.who;
      rvalid1_c  = !rst && ret_c.valid &&  ret_c.who;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         if (rvalid0_c) rdata0_q <= ret_data_c;
         if (rvalid1_c) rdata1_q <= ret_data_c;
      end
   end

   assign p0.rvalid = rvalid0_c;
   assign p1.rvalid = rvalid1_c;
   assign p0.rdata  = rst ? '0 : (rvalid0_c ? ret_data_c : rdata0_q);
   assign p1.rdata  = rst ? '0 : (rvalid1_c ? ret_data_c : rdata1_q);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a per-cycle reference model of
// grant order, ROM addressing and tagged returns.
module tb_sprite_rom_arbiter;
   import sprite_rom_arbiter_pkg::*;

   localparam int unsigned CRD_W  = 7;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              frame_start;
   logic [3:0]        p0_state, p1_state;
   logic              rom_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data = '0;

   sprite_rom_arbiter_if #(.CRD_W(CRD_W), .DATA_W(DATA_W)) p0_if ();
   sprite_rom_arbiter_if #(.CRD_W(CRD_W), .DATA_W(DATA_W)) p1_if ();

   sprite_rom_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .p0_state    (p0_state),
      .p1_state    (p1_state),
      .p0          (p0_if),
      .p1          (p1_if),
      .rom_en      (rom_en),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data)
   );

   always #5 clk = ~clk;

   // One-cycle ROM whose contents are a fixed scramble of the address.
   always @(posedge clk) if (rom_en) rom_data <= rom_addr ^ 16'hA5A5;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int spr_of(input logic [3:0] s);
      case (s)
         4'd0:       return 0;
         4'd1, 4'd2: return 1;
         4'd3:       return 2;
         4'd4:       return 3;
         4'd5:       return 4;
         default:    return 0;
      endcase
   endfunction

   // Reference model state: frames, last winner, the one return in flight, held data.
   int m_spr [2];
   int m_last;
   bit pend_v;
   int pend_who;
   int pend_data;
   int hold [2];

   always @(negedge clk) begin : cmp
      int g, px, py, a, e_rv0, e_rv1, e_rd0, e_rd1;
      bit oob;
      if (rst) begin
         chk("rst_gnt0", p0_if.gnt, 0);
         chk("rst_gnt1", p1_if.gnt, 0);
         chk("rst_en", rom_en, 0);
         chk("rst_addr", rom_addr, 0);
         chk("rst_rv0", p0_if.rvalid, 0);
         chk("rst_rv1", p1_if.rvalid, 0);
         chk("rst_rd0", p0_if.rdata, 0);
         chk("rst_rd1", p1_if.rdata, 0);
         m_spr[0] = 0; m_spr[1] = 0; m_last = 1; pend_v = 0;
         hold[0] = 0; hold[1] = 0;
      end else begin
         g = -1;
         if (p0_if.req && p1_if.req) g = (m_last == 1) ? 0 : 1;
         else if (p0_if.req)         g = 0;
         else if (p1_if.req)         g = 1;
         px  = (g == 1) ? int'(p1_if.px) : int'(p0_if.px);
         py  = (g == 1) ? int'(p1_if.py) : int'(p0_if.py);
         oob = (px >= 100) || (py >= 100);
         a   = (g >= 0) ? m_spr[g] * 10000 + py * 100 + px : 0;
         chk("gnt0", p0_if.gnt, g == 0);
         chk("gnt1", p1_if.gnt, g == 1);
         chk("onehot", p0_if.gnt && p1_if.gnt, 0);
         chk("rom_en", rom_en, (g >= 0) && !oob);
         if ((g >= 0) && !oob) chk("rom_addr", rom_addr, a);
         e_rv0 = pend_v && pend_who == 0;
         e_rv1 = pend_v && pend_who == 1;
         e_rd0 = e_rv0 ? pend_data : hold[0];
         e_rd1 = e_rv1 ? pend_data : hold[1];
         chk("rvalid0", p0_if.rvalid, e_rv0);
         chk("rvalid1", p1_if.rvalid, e_rv1);
         chk("rdata0", p0_if.rdata, e_rd0);
         chk("rdata1", p1_if.rdata, e_rd1);
         if (pend_v) hold[pend_who] = pend_data;
         pend_v    = g >= 0;
         pend_who  = g;
         pend_data = oob ? 0 : ((a ^ 32'hA5A5) & 32'hFFFF);
         if (g >= 0) m_last = g;
         if (frame_start) begin
            m_spr[0] = spr_of(p0_state);
            m_spr[1] = spr_of(p1_state);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int p, input bit r, input int x, input int y);
      if (p == 0) begin
         p0_if.req = r; p0_if.px = CRD_W'(x); p0_if.py = CRD_W'(y);
      end else begin
         p1_if.req = r; p1_if.px = CRD_W'(x); p1_if.py = CRD_W'(y);
      end
   endtask

   initial begin
      rst = 1'b1; frame_start = 1'b0; p0_state = 4'd0; p1_state = 4'd0;
      drive(0, 0, 0, 0);
      drive(1, 0, 0, 0);
      repeat (3) step();

      // Idle frame, single requester
      rst = 1'b0;
      drive(0, 1, 3, 2);
      @(negedge clk);
      chk("t1_gnt", p0_if.gnt, 1);
      chk("t1_addr", rom_addr, 203);
      step();
      drive(0, 0, 3, 2);
      @(negedge clk);
      chk("t1_rv0", p0_if.rvalid, 1);
      chk("t1_rv1", p1_if.rvalid, 0);
      chk("t1_rdata", p0_if.rdata, 32'hA56E);
      step();

      // Frame latch for player 1, then unknown-state fallback
      p1_state = 4'd4; frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      drive(1, 1, 0, 0);
      @(negedge clk);
      chk("t2_addr", rom_addr, 30000);
      step();
      drive(1, 0, 0, 0);
      p1_state = 4'd7; frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      drive(1, 1, 0, 0);
      @(negedge clk);
      chk("t2_fallback", rom_addr, 0);
      step();
      drive(1, 0, 0, 0);
      step();

      // Contention: alternating grants, gapless returns
      drive(0, 1, 1, 1);
      drive(1, 1, 2, 2);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t3_gnt", {p1_if.gnt, p0_if.gnt}, (k % 2 == 0) ? 1 : 2);
         if (k > 0) chk("t3_rv", {p1_if.rvalid, p0_if.rvalid}, (k % 2 == 1) ? 1 : 2);
         step();
      end
      drive(0, 0, 0, 0);
      drive(1, 0, 0, 0);
      @(negedge clk);
      chk("t3_rv_last", {p1_if.rvalid, p0_if.rvalid}, 2);
      step();

      // Fetch in the frame_start cycle still uses the old frame
      p0_state = 4'd3; frame_start = 1'b1;
      drive(0, 1, 0, 0);
      @(negedge clk);
      chk("t4_old", rom_addr, 0);
      step();
      frame_start = 1'b0;
      @(negedge clk);
      chk("t4_new", rom_addr, 20000);
      step();
      drive(0, 0, 0, 0);
      step();

      // Out-of-box column
      drive(0, 1, 100, 5);
      @(negedge clk);
      chk("t5_gnt", p0_if.gnt, 1);
      chk("t5_en", rom_en, 0);
      step();
      drive(0, 0, 0, 0);
      @(negedge clk);
      chk("t5_rv", p0_if.rvalid, 1);
      chk("t5_rdata", p0_if.rdata, 0);
      step();

      // Mixed traffic with frame changes
      for (int i = 0; i < 24; i++) begin
         drive(0, (i % 3) != 2, (i * 13) % 104, (i * 7) % 103);
         drive(1, (i % 4) != 0, (i * 29) % 101, (i * 11) % 106);
         frame_start = (i % 5) == 4;
         p0_state    = 4'((i * 3) % 9);
         p1_state    = 4'((i * 5) % 9);
         step();
      end
      frame_start = 1'b0;
      drive(1, 0, 0, 0);

      // Reset drops the in-flight fetch and restores idle frames
      p0_state = 4'd3; frame_start = 1'b1;
      drive(0, 0, 0, 0);
      step();
      frame_start = 1'b0;
      drive(0, 1, 0, 0);
      step();
      rst = 1'b1;
      drive(0, 0, 0, 0);
      @(negedge clk);
      chk("t6_rv", p0_if.rvalid, 0);
      chk("t6_rdata", p0_if.rdata, 0);
      step();
      rst = 1'b0;
      drive(0, 1, 0, 0);
      @(negedge clk);
      chk("t6_rv_after", p0_if.rvalid, 0);
      chk("t6_idle", rom_addr, 0);
      step();
      drive(0, 0, 0, 0);
      repeat (3) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
